// File: rtl/fpu_sched_pkg.sv
// Shared types, IEEE-754 field constants and helpers for the FPU operation scheduler.
package fpu_sched_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } sched_state_e;

  localparam int unsigned EXP_MSB = 30;
  localparam int unsigned EXP_LSB = 23;
  localparam int unsigned MANT_W  = 23;

  function automatic int unsigned max3(int unsigned x, int unsigned y, int unsigned z);
    int unsigned m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

  // Returns {nan, inf, zero} for a single-precision value.
  function automatic logic [2:0] fp_class(logic [31:0] v);
    logic exp_ones;
    logic exp_zero;
    logic mant_zero;
    exp_ones  = &v[EXP_MSB:EXP_LSB];
    exp_zero  = ~|v[EXP_MSB:EXP_LSB];
    mant_zero = ~|v[MANT_W-1:0];
    return {exp_ones & ~mant_zero, exp_ones & mant_zero, exp_zero & mant_zero};
  endfunction

endpackage

// File: rtl/fpu_op_scheduler_if.sv
// Request, datapath and response signals of the FPU operation scheduler.
// FPU_SCHED_EXC_EN adds the rsp_flags exception-class field to the response.
interface fpu_op_scheduler_if;

  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0;
  logic [1:0]  req_op1;
  logic [31:0] req_a0;
  logic [31:0] req_a1;
  logic [31:0] req_b0;
  logic [31:0] req_b1;

  logic [1:0]  unit_sel;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        unit_start;
  logic [31:0] unit_result;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
`ifdef FPU_SCHED_EXC_EN
  logic [2:0]  rsp_flags;
`endif

  // Scheduler side.
  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    input  unit_result, rsp_ready,
    output req_ready, unit_sel, unit_a, unit_b, unit_start,
    output rsp_valid, rsp_data, rsp_id
`ifdef FPU_SCHED_EXC_EN
    , output rsp_flags
`endif
  );

  // Requesters plus arithmetic units.
  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    output unit_result, rsp_ready,
    input  req_ready, unit_sel, unit_a, unit_b, unit_start,
    input  rsp_valid, rsp_data, rsp_id
`ifdef FPU_SCHED_EXC_EN
    , input rsp_flags
`endif
  );

endinterface

// File: rtl/fpu_rr_arbiter.sv
// Two-way round-robin arbiter; prio names the requester preferred on a tie.
module fpu_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic prio_q;

  always_comb begin
    gnt_id = 1'b0;
    gnt    = 2'b00;
    if (req == 2'b11) begin
      gnt_id = prio_q;
    end else begin
      gnt_id = req[1];
    end
    if (req != 2'b00) begin
      gnt = gnt_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (advance && (req != 2'b00)) begin
      prio_q <= ~gnt_id;
    end
  end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Two-requester front end for the shared non-pipelined FPU units: grant, issue, wait, respond.
// FPU_SCHED_EXC_EN adds rsp_flags = {nan, inf, zero} captured alongside rsp_data.
module fpu_op_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic                clk,
  input  logic                reset,
  fpu_op_scheduler_if.slave   bus,
  output logic                busy
);

  localparam int unsigned MAX_LAT = max3(ADD_LAT, MUL_LAT, DIV_LAT);
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  function automatic logic [CNT_W-1:0] lat_for(op_e op);
    case (op)
      OP_MUL:  return CNT_W'(MUL_LAT);
      OP_DIV:  return CNT_W'(DIV_LAT);
      default: return CNT_W'(ADD_LAT);
    endcase
  endfunction

  sched_state_e     state_q, state_d;
  op_e              op_q;
  logic [31:0]      a_q, b_q, data_q;
  logic             id_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load_cnt, dec_cnt, capture;

  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       gnt_id;
  logic       idle;
  logic       grant;

  assign idle    = (state_q == StIdle);
  // Requests are only visible to the arbiter while idle, so prio moves once per grant.
  assign arb_req = idle ? bus.req_valid : 2'b00;
  assign grant   = |gnt;

  fpu_rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (idle),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_cnt = 1'b0;
    dec_cnt  = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = StIssue;
      end
      StIssue: begin
        load_cnt = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (cnt_q == CNT_W'(1)) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          dec_cnt = 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (grant) begin
        op_q <= op_e'(gnt_id ? bus.req_op1 : bus.req_op0);
        a_q  <= gnt_id ? bus.req_a1 : bus.req_a0;
        b_q  <= gnt_id ? bus.req_b1 : bus.req_b0;
        id_q <= gnt_id;
      end
      if (load_cnt) begin
        cnt_q <= lat_for(op_q);
      end else if (dec_cnt) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        data_q <= bus.unit_result;
      end
    end
  end

`ifdef FPU_SCHED_EXC_EN
  logic [2:0] flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (capture) begin
      flags_q <= fp_class(bus.unit_result);
    end
  end

  assign bus.rsp_flags = flags_q;
`endif

  assign bus.req_ready  = gnt;
  assign bus.unit_sel   = op_q;
  assign bus.unit_a     = a_q;
  assign bus.unit_b     = b_q;
  assign bus.unit_start = (state_q == StIssue);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_data   = data_q;
  assign bus.rsp_id     = id_q;
  assign busy           = ~idle;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Self-checking bench for fpu_op_scheduler: directed scenarios plus randomized traffic
// against a timestamp-based reference model and a behavioural FPU unit model.
module tb_fpu_op_scheduler;

  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned MUL_LAT = 1;
  localparam int unsigned DIV_LAT = 4;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  fpu_op_scheduler_if bus ();

  fpu_op_scheduler #(
    .ADD_LAT (ADD_LAT),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned lat_of(logic [1:0] op);
    return (op == 2'b11) ? DIV_LAT : ((op == 2'b10) ? MUL_LAT : ADD_LAT);
  endfunction

  // Arithmetic unit: exact IEEE results for the directed operands, a fixed mix otherwise.
  function automatic logic [31:0] unit_fn(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    case ({op, a, b})
      {2'b00, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {2'b01, 32'h40000000, 32'h3F800000}: return 32'h3F800000;
      {2'b10, 32'h3F800000, 32'h40000000}: return 32'h40000000;
      {2'b11, 32'h40800000, 32'h40000000}: return 32'h40000000;
      {2'b11, 32'h00000000, 32'h00000000}: return 32'h7FC00000;
      {2'b11, 32'h3F800000, 32'h00000000}: return 32'h7F800000;
      {2'b10, 32'h00000000, 32'h3F800000}: return 32'h00000000;
      default: return (a ^ {b[15:0], b[31:16]}) + {30'b0, op} + 32'h13579BDF;
    endcase
  endfunction

  logic [1:0]  u_op;
  logic [31:0] u_a, u_b;
  int unsigned u_cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      u_cnt <= 0;
    end else if (bus.unit_start === 1'b1) begin
      u_cnt <= 1;
      u_op  <= bus.unit_sel;
      u_a   <= bus.unit_a;
      u_b   <= bus.unit_b;
    end else if (u_cnt != 0 && u_cnt < 1000) begin
      u_cnt <= u_cnt + 1;
    end
  end

  // Result is only correct in the cycle exactly LAT cycles after unit_start.
  assign bus.unit_result = (u_cnt != 0 && u_cnt == lat_of(u_op)) ? unit_fn(u_op, u_a, u_b)
                                                                 : (32'hBAD00000 | u_cnt);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.req_op0   = 2'b00;
    bus.req_op1   = 2'b00;
    bus.req_a0    = '0;
    bus.req_a1    = '0;
    bus.req_b0    = '0;
    bus.req_b1    = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    if (id == 0) begin
      bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
    end else begin
      bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
    end
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input int limit, output bit got, output int at_cyc);
    got = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        at_cyc = cyc;
        return;
      end
      step();
      settle();
    end
  endtask

  task automatic test_reset();
    logic [133:0] obs;
    reset = 1'b1;
    idle_inputs();
    #1;
    obs = {bus.req_ready, bus.unit_start, bus.rsp_valid, busy, bus.unit_sel, bus.unit_a,
           bus.unit_b, bus.rsp_data, bus.rsp_id};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, want 0", obs);
    end
    do_reset();
    step();
    settle();
    obs = {bus.req_ready, bus.unit_start, bus.rsp_valid, busy, bus.unit_sel, bus.unit_a,
           bus.unit_b, bus.rsp_data, bus.rsp_id};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: got %h, want 0", obs);
    end
`ifdef FPU_SCHED_EXC_EN
    vectors++;
    if (bus.rsp_flags !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, want 000", bus.rsp_flags);
    end
`endif
  endtask

  task automatic test_add();
    do_reset();
    set_req(0, 2'b00, 32'h3F800000, 32'h40000000);
    settle();
    vectors++;
    if (bus.req_ready !== 2'b01 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL add_grant: req_ready=%b busy=%b, want 01/0", bus.req_ready, busy);
    end
    step();
    bus.req_valid = 2'b00;
    settle();
    vectors++;
    if (bus.unit_start !== 1'b1 || bus.unit_sel !== 2'b00 || bus.unit_a !== 32'h3F800000 ||
        bus.unit_b !== 32'h40000000) begin
      miscompares++;
      $display("FAIL add_issue: start=%b sel=%b a=%h b=%h, want 1/00/3f800000/40000000",
               bus.unit_start, bus.unit_sel, bus.unit_a, bus.unit_b);
    end
    step();
    settle();
    vectors++;
    if (bus.unit_start !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL add_wait: start=%b valid=%b busy=%b, want 0/0/1",
               bus.unit_start, bus.rsp_valid, busy);
    end
    step();
    settle();
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h40400000 || bus.rsp_id !== 1'b0) begin
      miscompares++;
      $display("FAIL add_rsp: valid=%b data=%h id=%b, want 1/40400000/0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    step();
    settle();
    vectors++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL add_done: valid=%b busy=%b, want 0/0", bus.rsp_valid, busy);
    end
  endtask

  task automatic test_both_valid();
    bit got;
    int c, t0, t1;
    do_reset();
    set_req(0, 2'b01, 32'h40000000, 32'h3F800000);
    set_req(1, 2'b10, 32'h3F800000, 32'h40000000);
    settle();
    t0 = cyc;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL both_first_grant: req_ready=%b, want 01", bus.req_ready);
    end
    step();
    bus.req_valid[0] = 1'b0;
    settle();
    wait_rsp(20, got, c);
    vectors++;
    if (!got || bus.rsp_data !== 32'h3F800000 || bus.rsp_id !== 1'b0 || c != t0 + 3) begin
      miscompares++;
      $display("FAIL both_rsp0: got=%0d data=%h id=%b at=+%0d, want 1/3f800000/0/+3",
               got, bus.rsp_data, bus.rsp_id, c - t0);
    end
    vectors++;
    if (bus.req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL both_hs_no_grant: req_ready=%b, want 00", bus.req_ready);
    end
    step();
    settle();
    t1 = cyc;
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL both_second_grant: req_ready=%b, want 10", bus.req_ready);
    end
    step();
    bus.req_valid[1] = 1'b0;
    settle();
    wait_rsp(20, got, c);
    vectors++;
    if (!got || bus.rsp_data !== 32'h40000000 || bus.rsp_id !== 1'b1 || c != t1 + 3) begin
      miscompares++;
      $display("FAIL both_rsp1: got=%0d data=%h id=%b at=+%0d, want 1/40000000/1/+3",
               got, bus.rsp_data, bus.rsp_id, c - t1);
    end
    step();
    set_req(0, 2'b00, 32'h1, 32'h2);
    set_req(1, 2'b00, 32'h3, 32'h4);
    settle();
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL both_prio_back: req_ready=%b, want 01", bus.req_ready);
    end
  endtask

  task automatic test_div();
    do_reset();
    set_req(1, 2'b11, 32'h40800000, 32'h40000000);
    settle();
    vectors++;
    if (bus.req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL div_grant: req_ready=%b, want 10", bus.req_ready);
    end
    step();
    bus.req_valid = 2'b00;
    settle();
    for (int k = 1; k <= 5; k++) begin
      vectors++;
      if (busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.unit_start !== (k == 1)) begin
        miscompares++;
        $display("FAIL div_wait_%0d: busy=%b valid=%b start=%b, want 1/0/%0d",
                 k, busy, bus.rsp_valid, bus.unit_start, (k == 1));
      end
      step();
      settle();
    end
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h40000000 || bus.rsp_id !== 1'b1 ||
        busy !== 1'b1) begin
      miscompares++;
      $display("FAIL div_rsp: valid=%b data=%h id=%b busy=%b, want 1/40000000/1/1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy);
    end
  endtask

  task automatic test_backpressure();
    bit got;
    int c;
    logic [31:0] a, b, a2, b2;
    a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
    do_reset();
    bus.rsp_ready = 1'b0;
    set_req(0, 2'b10, a, b);
    settle();
    step();
    bus.req_valid = 2'b00;
    settle();
    wait_rsp(10, got, c);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL bp_rsp_timeout: rsp_valid=%b, want 1", bus.rsp_valid);
    end
    set_req(0, 2'b01, a2, b2);
    settle();
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== unit_fn(2'b10, a, b) ||
          bus.rsp_id !== 1'b0 || bus.req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: valid=%b data=%h id=%b ready=%b, want 1/%h/0/00",
                 k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready,
                 unit_fn(2'b10, a, b));
      end
      step();
      settle();
    end
    bus.rsp_ready = 1'b1;
    settle();
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL bp_handshake: valid=%b ready=%b, want 1/00", bus.rsp_valid, bus.req_ready);
    end
    step();
    settle();
    vectors++;
    if (bus.req_ready !== 2'b01 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next_grant: ready=%b valid=%b, want 01/0", bus.req_ready, bus.rsp_valid);
    end
    step();
    bus.req_valid = 2'b00;
    settle();
    wait_rsp(10, got, c);
    vectors++;
    if (!got || bus.rsp_data !== unit_fn(2'b01, a2, b2)) begin
      miscompares++;
      $display("FAIL bp_second_rsp: got=%0d data=%h, want 1/%h", got, bus.rsp_data,
               unit_fn(2'b01, a2, b2));
    end
  endtask

  task automatic test_reset_mid_op();
    bit got, seen;
    int c, t0;
    logic [133:0] obs;
    do_reset();
    set_req(0, 2'b11, $urandom, $urandom);
    settle();
    step();
    bus.req_valid = 2'b00;
    settle();
    step();
    settle();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_busy: busy=%b, want 1", busy);
    end
    reset = 1'b1;
    #1;
    obs = {bus.req_ready, bus.unit_start, bus.rsp_valid, busy, bus.unit_sel, bus.unit_a,
           bus.unit_b, bus.rsp_data, bus.rsp_id};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got %h, want 0", obs);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      settle();
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL rst_mid_no_rsp: activity seen=1, want 0");
    end
    set_req(0, 2'b10, 32'h3F800000, 32'h40000000);
    set_req(1, 2'b00, 32'h5, 32'h6);
    settle();
    t0 = cyc;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_mid_fresh_grant: req_ready=%b, want 01", bus.req_ready);
    end
    step();
    bus.req_valid[0] = 1'b0;
    settle();
    wait_rsp(10, got, c);
    vectors++;
    if (!got || bus.rsp_data !== 32'h40000000 || bus.rsp_id !== 1'b0 || c != t0 + 3) begin
      miscompares++;
      $display("FAIL rst_mid_fresh_rsp: got=%0d data=%h id=%b at=+%0d, want 1/40000000/0/+3",
               got, bus.rsp_data, bus.rsp_id, c - t0);
    end
  endtask

`ifdef FPU_SCHED_EXC_EN
  task automatic test_flags();
    req_t vec [3];
    logic [2:0] want [3];
    bit got;
    int c;
    vec[0] = '{op: 2'b11, a: 32'h00000000, b: 32'h00000000}; want[0] = 3'b100;
    vec[1] = '{op: 2'b11, a: 32'h3F800000, b: 32'h00000000}; want[1] = 3'b010;
    vec[2] = '{op: 2'b10, a: 32'h00000000, b: 32'h3F800000}; want[2] = 3'b001;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      set_req(0, vec[k].op, vec[k].a, vec[k].b);
      settle();
      step();
      bus.req_valid = 2'b00;
      settle();
      wait_rsp(10, got, c);
      vectors++;
      if (!got || bus.rsp_flags !== want[k]) begin
        miscompares++;
        $display("FAIL flags_%0d: got=%0d flags=%b data=%h, want 1/%b", k, got, bus.rsp_flags,
                 bus.rsp_data, want[k]);
      end
    end
  endtask
`endif

  // Model: the unit is free until a grant; a grant at cycle G shows unit_start at G+1 and a
  // response from G+2+LAT until accepted; the unit is free again the cycle after acceptance.
  task automatic test_random();
    req_t pend [2];
    bit   has [2];
    req_t cur;
    bit   inflight, mprio, gid;
    int   g_cyc, rsp_cyc;
    logic [1:0] exp_ready;
    logic exp_start, exp_valid;
    logic [4:0] obs, exp;
    do_reset();
    has[0] = 1'b0; has[1] = 1'b0;
    inflight = 1'b0; mprio = 1'b0; gid = 1'b0; g_cyc = 0; rsp_cyc = 0;
    for (int n = 0; n < 1200; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!has[i] && $urandom_range(0, 3) == 0) begin
          pend[i].op = 2'($urandom_range(0, 3));
          pend[i].a  = $urandom;
          pend[i].b  = $urandom;
          has[i] = 1'b1;
          set_req(i, pend[i].op, pend[i].a, pend[i].b);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      settle();
      exp_ready = 2'b00;
      if (!inflight && (has[0] || has[1])) begin
        gid = (has[0] && has[1]) ? mprio : has[1];
        exp_ready[gid] = 1'b1;
      end
      exp_start = inflight && (cyc == g_cyc + 1);
      exp_valid = inflight && (cyc >= rsp_cyc);
      exp = {exp_ready, exp_start, exp_valid, inflight};
      obs = {bus.req_ready, bus.unit_start, bus.rsp_valid, busy};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL rand_ctrl@%0d: {ready,start,valid,busy}=%b, want %b", n, obs, exp);
      end
      if (exp_start) begin
        vectors++;
        if (bus.unit_sel !== cur.op || bus.unit_a !== cur.a || bus.unit_b !== cur.b) begin
          miscompares++;
          $display("FAIL rand_issue@%0d: sel=%b a=%h b=%h, want %b/%h/%h", n, bus.unit_sel,
                   bus.unit_a, bus.unit_b, cur.op, cur.a, cur.b);
        end
      end
      if (exp_valid) begin
        vectors++;
        if (bus.rsp_data !== unit_fn(cur.op, cur.a, cur.b) || bus.rsp_id !== gid) begin
          miscompares++;
          $display("FAIL rand_rsp@%0d: data=%h id=%b, want %h/%b", n, bus.rsp_data, bus.rsp_id,
                   unit_fn(cur.op, cur.a, cur.b), gid);
        end
      end
      if (exp_valid && bus.rsp_ready) begin
        inflight = 1'b0;
      end else if (exp_ready != 2'b00) begin
        inflight = 1'b1;
        g_cyc    = cyc;
        cur      = pend[gid];
        rsp_cyc  = cyc + 2 + int'(lat_of(cur.op));
        mprio    = ~gid;
        has[gid] = 1'b0;
      end
      step();
      for (int i = 0; i < 2; i++) begin
        if (!has[i]) bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_both_valid();
    test_div();
    test_backpressure();
    test_reset_mid_op();
`ifdef FPU_SCHED_EXC_EN
    test_flags();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_op_scheduler.md
# fpu_op_scheduler

Two-requester front end for the shared non-pipelined FPU datapath: the adder/subtractor, multiplier and divider units. It arbitrates round-robin between two requesters and issues one operation at a time to the selected unit. It counts that unit's fixed latency, captures the result and returns it with the requester ID over a valid/ready response channel. It sits between the RISC-V core/test master side and the FPU arithmetic units.

## Interface
Parameters:
- ADD_LAT, 1: cycles from `unit_start` to a valid `unit_result` for ADD/SUB (minimum 1).
- MUL_LAT, 1: same, for MUL.
- DIV_LAT, 4: same, for DIV.

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid (bit i = requester i)
- req_ready  out  2  per-requester accept; one-hot pulse on grant
- req_op0 / req_op1  in  2  opcode: 00 ADD, 01 SUB (a−b), 10 MUL, 11 DIV (a/b)
- req_a0 / req_a1, req_b0 / req_b1  in  32  IEEE-754 single operands
- unit_sel  out  2  opcode routed to datapath mux
- unit_a, unit_b  out  32  registered operands to the datapath
- unit_start  out  1  one-cycle pulse starting the operation
- unit_result  in  32  selected unit's result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_data  out  32  captured result
- rsp_id  out  1  requester that issued the operation
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid` bit is set, grant one requester and pulse its `req_ready` that cycle.
  - Latch that requester's op, a and b into registers, plus its ID.
  - Go to ISSUE.
- Arbitration:
  - One-bit priority pointer `prio` holds the preferred requester; its reset value is 0.
  - If only one requester is valid, grant it.
  - If both are valid, grant requester `prio`.
  - After every grant, `prio` becomes the other requester (the ID not granted).
- ISSUE:
  - `unit_start`=1 for exactly one cycle.
  - Load the counter with the latency for the op: ADD_LAT, MUL_LAT or DIV_LAT.
  - Go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `unit_result` into `rsp_data` and go to RESP.
- RESP:
  - `rsp_valid`=1, with `rsp_data` and `rsp_id` held stable.
  - On `rsp_valid && rsp_ready`, return to IDLE.
  - No new request is granted in the handshake cycle.
- Operand stability: `unit_sel`, `unit_a` and `unit_b` are registers that do not change from ISSUE until the next grant.
- Width rule: the counter width is sized to hold the largest of the three latency parameters.
- Requester rule: a requester must hold its valid, op and operands until it receives `req_ready`; the scheduler never drops a pending valid request.

## Timing
- Reset values:
  - `req_ready`=0, `unit_start`=0, `rsp_valid`=0, `busy`=0.
  - `unit_sel`=0, `unit_a`=0, `unit_b`=0, `rsp_data`=0, `rsp_id`=0.
  - `prio`=0, state IDLE.
- Timeline for one operation:
  - Grant at cycle T.
  - `unit_start` at T+1.
  - Result sampled at T+1+LAT.
  - `rsp_valid` first high at T+2+LAT.
- Minimum request-to-request spacing is LAT+3 cycles, with `rsp_ready` tied high.
- Reset asserted mid-operation (any state):
  - The in-flight op is discarded; no response is produced.
  - All outputs return to their reset values asynchronously.
- Backpressure: while `rsp_ready`=0 the scheduler stays in RESP indefinitely, `req_ready` stays 0 and new requests wait.

## Configuration
- FPU_SCHED_EXC_EN defined:
  - Adds output `rsp_flags` [2:0] = {nan, inf, zero}, captured together with `rsp_data`.
  - nan: exp=FF, mant≠0. inf: exp=FF, mant=0. zero: exp=00, mant=0.
  - Reset value 0.
- FPU_SCHED_EXC_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `fpu_sched_pkg` holds:
  - opcode enum (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_DIV`);
  - FSM state enum;
  - field constants `EXP_MSB`=30, `EXP_LSB`=23, `MANT_W`=23.
- One sub-module, `fpu_rr_arbiter`:
  - 2-way round-robin arbiter with inputs `req`[1:0] and `advance`;
  - outputs one-hot `gnt`[1:0] and `gnt_id`;
  - owns `prio`.

## Test plan
- ADD_LAT=1, req0 ADD a=3F800000 b=40000000, `rsp_ready`=1 → `unit_start` 1 cycle after grant; `rsp_data`=40400000, `rsp_id`=0, `rsp_valid` 3 cycles after grant.
- Both valid at reset exit: req0 SUB 40000000−3F800000, req1 MUL 3F800000×40000000 → req0 granted first (response 3F800000), then req1 (response 40000000), then `prio` returns to 0.
- DIV_LAT=4, req1 DIV a=40800000 b=40000000 → `rsp_data`=40000000, `rsp_valid` 6 cycles after grant, `busy` high throughout.
- Hold `rsp_ready`=0 for 10 cycles with req0 pending → `rsp_valid` and `rsp_data` stable, `req_ready`=0; pending request granted the cycle after the handshake completes.
- Assert `reset` during WAIT → all outputs 0 immediately; no `rsp_valid` afterwards; next request behaves as from a fresh reset.
- FPU_SCHED_EXC_EN defined, unit returns 7FC00000 / 7F800000 / 00000000 → `rsp_flags` = 100 / 010 / 001.
